odometer_meas_ctrl: RTL and testbench
=====================================

ODOMETER_MEAS_CTRL -- requirements
Module: odometer_meas_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 12-bit result entries held.
REQ-002 Parameter TRIG_CYCLES, default 2, MEAS_TRIG high width in cycles.
REQ-003 CLK  input  1  single clock; every flop is rising-edge CLK.
REQ-004 RESETB  input  1  asynchronous active-low reset.
REQ-005 START_MEAS  input  1  one-cycle request to begin a measurement burst.
REQ-006 NUM_MEAS  input  3  measurements per burst; 0 means 8.
REQ-007 MEAS_WINDOW  input  8  wait cycles between trigger release and capture; 0 means 256.
REQ-008 BF_COUNT  input  12  beat-frequency count from the odometer; stable during CAPTURE.
REQ-009 SCAN_LOAD  input  1  pop FIFO head into the scan shift register.
REQ-010 SCAN_EN  input  1  shift the scan register by one bit per cycle.
REQ-011 VDD, VSS  input  1 each  supply pins, passed through with no logic function.
REQ-012 MEAS_TRIG  output  1  measurement trigger to the odometer.
REQ-013 BUSY  output  1  high in any state other than IDLE.
REQ-014 DONE  output  1  one-cycle pulse at end of burst.
REQ-015 FIFO_LEVEL  output  3  number of stored entries, 0..FIFO_DEPTH.
REQ-016 OVERFLOW  output  1  sticky; a capture was dropped because the FIFO was full.
REQ-017 SCAN_OUT  output  1  MSB of the scan shift register.

Function
REQ-018 FSM states IDLE, TRIG, WAIT, CAPTURE, FIN; encoding Moore, registered outputs.
REQ-019 IDLE: START_MEAS=1 latches NUM_MEAS and MEAS_WINDOW, clears sample counter and OVERFLOW, goes to TRIG next cycle.
REQ-020 START_MEAS while BUSY=1 is ignored; latched settings do not change mid-burst.
REQ-021 TRIG: MEAS_TRIG=1 for exactly TRIG_CYCLES cycles, then WAIT.
REQ-022 WAIT: 8-bit down-counter loaded with latched MEAS_WINDOW (0 loads 256 via 9-bit counter); stays exactly that many cycles, then CAPTURE.
REQ-023 CAPTURE: one cycle; BF_COUNT written to FIFO tail if not full, else dropped and OVERFLOW set; sample counter increments.
REQ-024 After CAPTURE: counter equal to latched NUM_MEAS (0 treated as 8) goes to FIN, otherwise TRIG.
REQ-025 FIN: DONE=1 for one cycle, then IDLE.
REQ-026 Burst length in cycles = N*(TRIG_CYCLES + W + 1) + 1 from first TRIG cycle through FIN.
REQ-027 SCAN_LOAD with FIFO non-empty: head copied into 12-bit shift register, read pointer advances, FIFO_LEVEL decrements, same cycle.
REQ-028 SCAN_LOAD with FIFO empty: shift register loads 12'h000, pointers and level unchanged.
REQ-029 SCAN_LOAD and CAPTURE write in the same cycle: both take effect, FIFO_LEVEL unchanged; full FIFO plus simultaneous pop accepts the write (no overflow).
REQ-030 SCAN_EN=1 (without SCAN_LOAD): shift register shifts left, LSB filled with 0; SCAN_LOAD has priority over SCAN_EN.
REQ-031 SCAN_OUT = shift register bit 11; data leaves MSB first, 12 shifts per word.
REQ-032 Pointers wrap modulo FIFO_DEPTH; FIFO_LEVEL never exceeds FIFO_DEPTH nor underflows.

Reset
REQ-033 RESETB low asynchronously forces IDLE, all counters and pointers 0, FIFO_LEVEL=0, shift register 0.
REQ-034 Reset values: MEAS_TRIG=0, BUSY=0, DONE=0, OVERFLOW=0, SCAN_OUT=0.
REQ-035 Reset asserted mid-burst aborts it; no DONE pulse; stored FIFO entries are discarded.
REQ-036 Reset release is synchronous to CLK at integration level; block requires no reset-release cycles before START_MEAS.

Structure
REQ-037 Package odometer_pkg holds the FSM state enum, BF_WIDTH=12 and default FIFO_DEPTH/TRIG_CYCLES constants.
REQ-038 FIFO is one sub-module, odometer_result_fifo (write, pop, level, full, empty); FSM and scan register stay in the top.

Verification
REQ-039 Reset, START_MEAS with NUM_MEAS=1, MEAS_WINDOW=3, BF_COUNT=12'hA5C -> MEAS_TRIG high 2 cycles, CAPTURE 3 cycles later, DONE pulse, FIFO_LEVEL=1.
REQ-040 NUM_MEAS=0, MEAS_WINDOW=1, no pops -> 8 captures, FIFO_LEVEL=4, OVERFLOW=1, DONE after 33 cycles.
REQ-041 FIFO holding 12'h800 then 12'h001; SCAN_LOAD then 12 SCAN_EN -> SCAN_OUT 1,0x11; second load -> 0x11,1; FIFO_LEVEL 0.
REQ-042 FIFO full, SCAN_LOAD coincident with CAPTURE -> level stays 4, OVERFLOW stays 0, newest value present at tail.
REQ-043 RESETB pulsed low during WAIT of 3-sample burst -> all outputs at reset values immediately, no DONE, FIFO_LEVEL=0.
REQ-044 START_MEAS during BUSY with changed NUM_MEAS -> ignored, burst completes with originally latched count.

Source files
------------

// File: rtl/odometer_pkg.sv
// Shared definitions for the odometer measurement controller.
//   meas_state_t    : burst sequencer states
//   BF_WIDTH        : width of one beat-frequency result word
//   DEF_FIFO_DEPTH  : default number of stored results
//   DEF_TRIG_CYCLES : default trigger pulse width in cycles
package odometer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FIN     = 3'd4
  } meas_state_t;

  localparam int BF_WIDTH        = 12;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_TRIG_CYCLES = 2;

endpackage

// File: rtl/odometer_result_fifo.sv
// Result FIFO for beat-frequency words.
//   clk, resetb : clock, async active-low reset (pointers/level cleared)
//   wr_en       : write wr_data at the tail (dropped when full unless popping)
//   pop         : advance the head (ignored when empty)
//   rd_data     : current head word, valid when not empty
//   level       : stored entries, 0..DEPTH (DEPTH must be <= 7)
//   full, empty : level flags
module odometer_result_fifo
  import odometer_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = BF_WIDTH
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [2:0]       level,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_wr;

  assign full    = (level == 3'(DEPTH));
  assign empty   = (level == 3'd0);
  assign rd_data = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign do_wr   = wr_en && (!full || do_pop);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 3'd0;
    end else begin
      if (do_wr)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/odometer_meas_ctrl.sv
// Odometer measurement burst controller with result FIFO and scan readout.
//   clk, resetb        : clock, async active-low reset
//   start_meas         : begin a burst (ignored while busy)
//   num_meas           : samples per burst, 0 = 8
//   meas_window        : wait cycles after trigger, 0 = 256
//   bf_count           : odometer result, captured in CAPTURE
//   scan_load, scan_en : pop FIFO head into scan register / shift it left
//   vdd, vss           : supply pass-through, no logic function
//   meas_trig, busy, done, overflow : registered status outputs
//   fifo_level         : stored results
//   scan_out           : scan register MSB
//
// state   | meaning
// IDLE    | waiting for start_meas
// TRIG    | meas_trig high for TRIG_CYCLES cycles
// WAIT    | measurement window countdown
// CAPTURE | push bf_count, count the sample
// FIN     | one-cycle done pulse
module odometer_meas_ctrl
  import odometer_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TRIG_CYCLES = DEF_TRIG_CYCLES
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                start_meas,
  input  logic [2:0]          num_meas,
  input  logic [7:0]          meas_window,
  input  logic [BF_WIDTH-1:0] bf_count,
  input  logic                scan_load,
  input  logic                scan_en,
  input  logic                vdd,
  input  logic                vss,
  output logic                meas_trig,
  output logic                busy,
  output logic                done,
  output logic [2:0]          fifo_level,
  output logic                overflow,
  output logic                scan_out
);

  meas_state_t         state, state_nxt;
  logic [2:0]          num_lat;
  logic [7:0]          win_lat;
  logic [8:0]          timer;
  logic [3:0]          sample_cnt;
  logic [3:0]          num_eff;
  logic [8:0]          win_eff;
  logic [BF_WIDTH-1:0] scan_sr;
  logic [BF_WIDTH-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                capture;
  logic                unused_supply;

  assign unused_supply = vdd ^ vss;

  assign num_eff = (num_lat == 3'd0) ? 4'd8 : {1'b0, num_lat};
  assign win_eff = (win_lat == 8'd0) ? 9'd256 : {1'b0, win_lat};
  assign capture = (state == ST_CAPTURE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_meas) state_nxt = ST_TRIG;
      ST_TRIG:    if (timer == 9'd0) state_nxt = ST_WAIT;
      ST_WAIT:    if (timer == 9'd0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ((sample_cnt + 4'd1) == num_eff) ? ST_FIN : ST_TRIG;
      ST_FIN:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they stay aligned with the state flop.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      meas_trig  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      num_lat    <= 3'd0;
      win_lat    <= 8'd0;
      timer      <= 9'd0;
      sample_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      meas_trig <= (state_nxt == ST_TRIG);
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_FIN);

      if (state == ST_IDLE && start_meas) begin
        num_lat    <= num_meas;
        win_lat    <= meas_window;
        sample_cnt <= 4'd0;
        overflow   <= 1'b0;
      end

      if (capture) begin
        sample_cnt <= sample_cnt + 4'd1;
        if (fifo_full && !scan_load)
          overflow <= 1'b1;
      end

      // Timer counts down to zero; terminal count ends TRIG and WAIT.
      if (state_nxt == ST_TRIG && state != ST_TRIG)
        timer <= 9'(TRIG_CYCLES - 1);
      else if (state_nxt == ST_WAIT && state != ST_WAIT)
        timer <= win_eff - 9'd1;
      else if (timer != 9'd0)
        timer <= timer - 9'd1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)
      scan_sr <= '0;
    else if (scan_load)
      scan_sr <= fifo_empty ? '0 : fifo_head;
    else if (scan_en)
      scan_sr <= {scan_sr[BF_WIDTH-2:0], 1'b0};
  end

  assign scan_out = scan_sr[BF_WIDTH-1];

  odometer_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BF_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .resetb  (resetb),
    .wr_en   (capture),
    .wr_data (bf_count),
    .pop     (scan_load),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_odometer_meas_ctrl.sv
module tb_odometer_meas_ctrl;

  localparam int DEPTH = 4;
  localparam int TC    = 2;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        start_meas = 1'b0;
  logic [2:0]  num_meas = '0;
  logic [7:0]  meas_window = '0;
  logic [11:0] bf_count = '0;
  logic        scan_load = 1'b0;
  logic        scan_en = 1'b0;
  logic        vdd = 1'b1;
  logic        vss = 1'b0;
  logic        meas_trig, busy, done, overflow, scan_out;
  logic [2:0]  fifo_level;

  int checks = 0;
  int fails  = 0;

  // Reference model: queue of stored results, sticky overflow, last popped word.
  logic [11:0] mq[$];
  logic        exp_ovf = 1'b0;
  logic [11:0] last_pop = '0;

  odometer_meas_ctrl #(.FIFO_DEPTH(DEPTH), .TRIG_CYCLES(TC)) dut (
    .clk(clk), .resetb(resetb), .start_meas(start_meas), .num_meas(num_meas),
    .meas_window(meas_window), .bf_count(bf_count), .scan_load(scan_load),
    .scan_en(scan_en), .vdd(vdd), .vss(vss), .meas_trig(meas_trig), .busy(busy),
    .done(done), .fifo_level(fifo_level), .overflow(overflow), .scan_out(scan_out)
  );

  always #5 clk = ~clk;

  // Applies the model for the coming edge using the inputs currently driven, then clocks.
  task automatic tick(input bit cap);
    if (scan_load) begin
      if (mq.size() > 0) last_pop = mq.pop_front();
      else last_pop = '0;
    end
    if (cap) begin
      if (mq.size() < DEPTH) mq.push_back(bf_count);
      else exp_ovf = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  // pop_mode: 0 none, 1 random, 2 exactly on capture cycles. bf_fix < 0 means random data.
  task automatic run_burst(input int nc, input int wc, input int pop_mode, input bit poke,
                           input int bf_fix, output int done_at, output int trig_total,
                           output int done_pulses, output int busy_cycles);
    int n, w, period, total;
    bit cap;
    n = (nc == 0) ? 8 : nc;
    w = (wc == 0) ? 256 : wc;
    period = TC + w + 1;
    total = n * period + 1;
    done_at = -1; trig_total = 0; done_pulses = 0; busy_cycles = 0;
    num_meas = 3'(nc); meas_window = 8'(wc);
    start_meas = 1'b1; scan_load = 1'b0; scan_en = 1'b0;
    exp_ovf = 1'b0;
    tick(1'b0);
    start_meas = 1'b0;
    for (int idx = 0; idx < total + 2; idx++) begin
      if (meas_trig) trig_total++;
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (done_at < 0) done_at = idx;
      end
      cap = (idx < n * period) && ((idx % period) == period - 1);
      bf_count = (bf_fix < 0) ? 12'($urandom) : 12'(bf_fix);
      case (pop_mode)
        1:       scan_load = ($urandom_range(0, 3) == 0);
        2:       scan_load = cap;
        default: scan_load = 1'b0;
      endcase
      if (poke && idx < total && $urandom_range(0, 2) == 0) begin
        start_meas = 1'b1;
        num_meas = 3'($urandom);
        meas_window = 8'($urandom);
      end else begin
        start_meas = 1'b0;
      end
      tick(cap);
    end
    scan_load = 1'b0;
    start_meas = 1'b0;
  endtask

  // Loads the head and performs 12 shifts; obs collects SCAN_OUT MSB-first, tail is after the 12th shift.
  task automatic scan_word(output logic [11:0] obs, output logic [11:0] want, output logic tail);
    scan_en = 1'b0;
    scan_load = 1'b1;
    tick(1'b0);
    want = last_pop;
    scan_load = 1'b0;
    obs[11] = scan_out;
    for (int b = 10; b >= 0; b--) begin
      scan_en = 1'b1;
      tick(1'b0);
      obs[b] = scan_out;
    end
    tick(1'b0);
    tail = scan_out;
    scan_en = 1'b0;
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    #12;
    checks++; if (meas_trig !== 1'b0) begin fails++; $display("FAIL reset_meas_trig: got %b want 0", meas_trig); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (scan_out !== 1'b0) begin fails++; $display("FAIL reset_scan_out: got %b want 0", scan_out); end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    @(negedge clk);
    resetb = 1'b1;
    mq.delete(); exp_ovf = 1'b0; last_pop = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int da, tt, dp, bc;
    logic [11:0] obs, want;
    logic tail;
    run_burst(1, 3, 0, 1'b0, 12'hA5C, da, tt, dp, bc);
    checks++; if (tt != 2) begin fails++; $display("FAIL single_trig_cycles: got %0d want 2", tt); end
    checks++; if (da != 6) begin fails++; $display("FAIL single_done_at: got %0d want 6", da); end
    checks++; if (dp != 1) begin fails++; $display("FAIL single_done_pulses: got %0d want 1", dp); end
    checks++; if (bc != 7) begin fails++; $display("FAIL single_busy_cycles: got %0d want 7", bc); end
    checks++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    scan_word(obs, want, tail);
    checks++; if (obs !== 12'hA5C) begin fails++; $display("FAIL single_word: got %h want a5c", obs); end
  endtask

  task automatic test_overflow;
    int da, tt, dp, bc;
    logic [11:0] obs, want;
    logic tail;
    run_burst(0, 1, 0, 1'b0, -1, da, tt, dp, bc);
    checks++; if (da != 32) begin fails++; $display("FAIL ovf_done_at: got %0d want 32", da); end
    checks++; if (bc != 33) begin fails++; $display("FAIL ovf_busy_cycles: got %0d want 33", bc); end
    checks++; if (tt != 16) begin fails++; $display("FAIL ovf_trig_cycles: got %0d want 16", tt); end
    checks++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      scan_word(obs, want, tail);
      checks++; if (obs !== want) begin fails++; $display("FAIL ovf_drain_word%0d: got %h want %h", i, obs, want); end
    end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL ovf_drained_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_scan;
    int da, tt, dp, bc;
    logic [11:0] obs, want;
    logic tail;
    run_burst(1, 1, 0, 1'b0, 12'h800, da, tt, dp, bc);
    run_burst(1, 1, 0, 1'b0, 12'h001, da, tt, dp, bc);
    checks++; if (fifo_level !== 3'd2) begin fails++; $display("FAIL scan_level_pre: got %0d want 2", fifo_level); end
    scan_word(obs, want, tail);
    checks++; if (obs !== 12'h800) begin fails++; $display("FAIL scan_word0: got %h want 800", obs); end
    checks++; if (tail !== 1'b0) begin fails++; $display("FAIL scan_tail0: got %b want 0", tail); end
    scan_word(obs, want, tail);
    checks++; if (obs !== 12'h001) begin fails++; $display("FAIL scan_word1: got %h want 001", obs); end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL scan_level_post: got %0d want 0", fifo_level); end
    run_burst(1, 2, 0, 1'b0, 12'h800, da, tt, dp, bc);
    scan_load = 1'b1; tick(1'b0);
    checks++; if (scan_out !== 1'b1) begin fails++; $display("FAIL scan_load_msb: got %b want 1", scan_out); end
    tick(1'b0);
    scan_load = 1'b0;
    checks++; if (scan_out !== 1'b0) begin fails++; $display("FAIL scan_empty_load: got %b want 0", scan_out); end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL scan_empty_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_pop_during_capture;
    int da, tt, dp, bc;
    logic [11:0] obs, want, newest;
    logic tail;
    run_burst(4, 2, 0, 1'b0, -1, da, tt, dp, bc);
    checks++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL popcap_full: got %0d want 4", fifo_level); end
    run_burst(1, 2, 2, 1'b0, -1, da, tt, dp, bc);
    newest = mq[mq.size() - 1];
    checks++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL popcap_level: got %0d want 4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL popcap_overflow: got %b want 0", overflow); end
    checks++; if (scan_out !== last_pop[11]) begin fails++; $display("FAIL popcap_scan_msb: got %b want %b", scan_out, last_pop[11]); end
    for (int i = 0; i < DEPTH; i++) begin
      scan_word(obs, want, tail);
      checks++; if (obs !== want) begin fails++; $display("FAIL popcap_word%0d: got %h want %h", i, obs, want); end
      if (i == DEPTH - 1) begin
        checks++; if (obs !== newest) begin fails++; $display("FAIL popcap_tail: got %h want %h", obs, newest); end
      end
    end
  endtask

  task automatic test_start_ignored;
    int da, tt, dp, bc;
    run_burst(2, 3, 0, 1'b1, -1, da, tt, dp, bc);
    checks++; if (da != 12) begin fails++; $display("FAIL ignore_done_at: got %0d want 12", da); end
    checks++; if (tt != 4) begin fails++; $display("FAIL ignore_trig_cycles: got %0d want 4", tt); end
    checks++; if (bc != 13) begin fails++; $display("FAIL ignore_busy_cycles: got %0d want 13", bc); end
    checks++; if (fifo_level !== 3'(mq.size())) begin fails++; $display("FAIL ignore_level: got %0d want %0d", fifo_level, mq.size()); end
  endtask

  task automatic test_random;
    int da, tt, dp, bc, nc, wc, n, w;
    logic [11:0] obs, want;
    logic tail;
    for (int it = 0; it < 6; it++) begin
      nc = $urandom_range(0, 7);
      wc = (it == 2) ? 0 : $urandom_range(1, 6);
      n = (nc == 0) ? 8 : nc;
      w = (wc == 0) ? 256 : wc;
      run_burst(nc, wc, $urandom_range(0, 2), 1'b0, -1, da, tt, dp, bc);
      checks++; if (da != n * (TC + w + 1)) begin fails++; $display("FAIL rnd%0d_done_at: got %0d want %0d", it, da, n * (TC + w + 1)); end
      checks++; if (tt != n * TC) begin fails++; $display("FAIL rnd%0d_trig: got %0d want %0d", it, tt, n * TC); end
      checks++; if (bc != n * (TC + w + 1) + 1) begin fails++; $display("FAIL rnd%0d_busy: got %0d want %0d", it, bc, n * (TC + w + 1) + 1); end
      checks++; if (dp != 1) begin fails++; $display("FAIL rnd%0d_done_pulses: got %0d want 1", it, dp); end
      checks++; if (fifo_level !== 3'(mq.size())) begin fails++; $display("FAIL rnd%0d_level: got %0d want %0d", it, fifo_level, mq.size()); end
      checks++; if (overflow !== exp_ovf) begin fails++; $display("FAIL rnd%0d_overflow: got %b want %b", it, overflow, exp_ovf); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (mq.size() > 0) begin
        scan_word(obs, want, tail);
        checks++; if (obs !== want) begin fails++; $display("FAIL rnd_drain%0d: got %h want %h", i, obs, want); end
      end
    end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL rnd_drained_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_reset_mid_burst;
    int da, tt, dp, bc, seen_done, seen_busy;
    run_burst(1, 1, 0, 1'b0, 12'hFFF, da, tt, dp, bc);
    checks++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL rstmid_prefill: got %0d want 1", fifo_level); end
    num_meas = 3'd3; meas_window = 8'd5; start_meas = 1'b1;
    tick(1'b0);
    start_meas = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    #2;
    resetb = 1'b0;
    mq.delete(); exp_ovf = 1'b0;
    #1;
    checks++; if (meas_trig !== 1'b0) begin fails++; $display("FAIL rstmid_meas_trig: got %b want 0", meas_trig); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL rstmid_done: got %b want 0", done); end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
    checks++; if (scan_out !== 1'b0) begin fails++; $display("FAIL rstmid_scan_out: got %b want 0", scan_out); end
    @(negedge clk);
    resetb = 1'b1;
    seen_done = 0; seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    checks++; if (seen_done != 0) begin fails++; $display("FAIL rstmid_no_done: got %0d want 0", seen_done); end
    checks++; if (seen_busy != 0) begin fails++; $display("FAIL rstmid_no_busy: got %0d want 0", seen_busy); end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL rstmid_level_after: got %0d want 0", fifo_level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_scan();
    test_pop_during_capture();
    test_start_ignored();
    test_random();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
